sync_decoder: RTL and testbench

Composite-sync decoder for the video subsystem: the receive-side counterpart of the CRT sync generator. It samples an external composite sync line, classifies each pulse as equalizing, horizontal or broad (vertical), regenerates line/frame strobes and position counters, and tracks horizontal lock. A CPU-visible indexed register port (address/data pair) exposes lock state, measured line period, current line and lines per frame.

---
 rtl/sync_decoder.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_sync_decoder.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_decoder.sv
// sync_decoder: composite-sync decoder for the video receive path.
// It samples an asynchronous, active-low composite sync line and measures
// the width of each sync tip. Each pulse is classed as equalizing,
// horizontal or broad. From these pulses the block produces line and frame
// strobes, a cycles-since-hsync counter, the current line number and a
// horizontal lock flag. An indexed address/data register pair exposes the
// measured state to the CPU.
//
// Build option: define SYNC_DECODER_IRQ_EN to add the frame interrupt
// output irq. Without it, status bit 0 reads as zero.

module sync_decoder #(
  parameter int CNT_W  = 10,  // horizontal counter / period width
  parameter int EQ_MAX = 28,  // widest equalizing pulse, in clk
  parameter int HS_MAX = 64,  // widest horizontal pulse, in clk
  parameter int TOL    = 4,   // allowed line-to-line period change while locking
  parameter int LOCK_N = 8    // consecutive in-tolerance lines needed for lock
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_in,
  input  logic             AD,
  input  logic [7:0]       DI,
  output logic [7:0]       DO,
  input  logic             rw,
  input  logic             cs,
  output logic             hs_pulse,
  output logic             vs_pulse,
  output logic             locked,
  output logic [8:0]       line,
  output logic [CNT_W-1:0] hcnt
`ifdef SYNC_DECODER_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int GOOD_W = $clog2(LOCK_N + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  EQ_LIM    = CNT_W'(EQ_MAX);
  localparam logic [CNT_W-1:0]  HS_LIM    = CNT_W'(HS_MAX);
  localparam logic [CNT_W-1:0]  TOL_LIM   = CNT_W'(TOL);
  localparam logic [GOOD_W-1:0] GOOD_LIM  = GOOD_W'(LOCK_N);
  localparam logic [8:0]        LINE_MAX  = 9'd511;
  localparam logic [2:0]        BROAD_MAX = 3'd7;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  // Input synchronizer and edge detection.
  logic s1, s2, s3;
  logic fall, rise;
  logic rise_q;

  // Pulse measurement and classification.
  logic [CNT_W-1:0] pw;
  logic             pulse_eq, pulse_hs, pulse_br;
  logic             frame_start;

  // Line timing state.
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] per_new;
  logic [CNT_W-1:0] per_diff;
  logic             in_tol;
  logic             hcnt_sat;
  logic [8:0]       lpf;
  logic [2:0]       broad_run;
  logic             skip;
  logic             hs_upd;

  // Lock tracker.
  lock_state_t       state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d;

  // CPU register port.
  logic [4:0] addr;
  logic [7:0] rd_data;
  logic       irq_bit;
  logic       status_rd;
  logic       unused_di;

  assign unused_di = ^DI[7:5];

  // Bring the asynchronous sync line into the clk domain.
  // NOTE: every clocked register uses non-blocking assignments. The three
  // flops therefore shift by one stage per edge and do not collapse into a
  // single flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= sync_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign fall = s3 & ~s2;
  assign rise = ~s3 & s2;

  // Count the edges on which the synchronized line is low. The count is
  // restarted on the falling edge and held after the rising edge, so it is
  // still valid one clk later when the pulse is classified.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pw     <= '0;
      rise_q <= 1'b0;
    end else begin
      rise_q <= rise;
      if (fall) begin
        pw <= CNT_W'(1);
      end else if (!s2 && pw != CNT_MAX) begin
        pw <= pw + 1'b1;
      end
    end
  end

  assign pulse_eq    = rise_q && (pw <= EQ_LIM);
  assign pulse_hs    = rise_q && (pw > EQ_LIM) && (pw <= HS_LIM);
  assign pulse_br    = rise_q && (pw > HS_LIM);
  assign frame_start = pulse_br && (broad_run == 3'd2);

  // A horizontal strobe ends a line that is one cycle longer than the
  // counter value reached. The stored period is therefore the true strobe
  // spacing: 512 for a 512-clk line.
  assign per_new  = (hcnt == CNT_MAX) ? CNT_MAX : hcnt + 1'b1;
  assign per_diff = (per_new >= period) ? per_new - period : period - per_new;
  assign in_tol   = (per_diff <= TOL_LIM);
  assign hcnt_sat = (hcnt == CNT_MAX);
  assign hs_upd   = pulse_hs && !skip;

  // Line/frame timing: strobes, counters, period and the skip marker that
  // hides the first line after any non-horizontal pulse from the lock logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt      <= '0;
      period    <= '0;
      line      <= '0;
      lpf       <= '0;
      broad_run <= '0;
      skip      <= 1'b1;
      hs_pulse  <= 1'b0;
      vs_pulse  <= 1'b0;
    end else begin
      hs_pulse <= pulse_hs;
      vs_pulse <= frame_start;
      if (pulse_hs) begin
        period    <= per_new;
        hcnt      <= '0;
        skip      <= 1'b0;
        broad_run <= '0;
        if (line != LINE_MAX) begin
          line <= line + 1'b1;
        end
      end else begin
        if (!hcnt_sat) begin
          hcnt <= hcnt + 1'b1;
        end
        if (pulse_eq) begin
          skip      <= 1'b1;
          broad_run <= '0;
        end
        if (pulse_br) begin
          skip <= 1'b1;
          if (broad_run != BROAD_MAX) begin
            broad_run <= broad_run + 1'b1;
          end
        end
        if (frame_start) begin
          lpf  <= line;
          line <= '0;
        end
      end
    end
  end

  // Lock state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEARCH;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  // Lock next state. A line with no hsync at all, shown by the counter
  // saturating, always forces a fresh search.
  // NOTE: defaults come first so every path assigns every output, which
  // keeps this a pure mux and never an inferred latch.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    unique case (state_q)
      SEARCH: begin
        if (hs_upd) begin
          if (in_tol) begin
            good_d = good_q + 1'b1;
            if (good_q + 1'b1 == GOOD_LIM) begin
              state_d = LOCKED;
            end
          end else begin
            good_d = '0;
          end
        end
      end
      LOCKED: begin
        if (hs_upd && !in_tol) begin
          state_d = SEARCH;
          good_d  = '0;
        end
      end
      default: begin
        state_d = SEARCH;
        good_d  = '0;
      end
    endcase
    if (hcnt_sat) begin
      state_d = SEARCH;
      good_d  = '0;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign status_rd = cs && rw && AD && (addr == 5'd0);

`ifdef SYNC_DECODER_IRQ_EN
  // Frame interrupt: set at frame start and cleared by a status read. Set
  // wins if both happen on the same edge, so a frame is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= 1'b0;
    end else if (frame_start) begin
      irq <= 1'b1;
    end else if (status_rd) begin
      irq <= 1'b0;
    end
  end
  assign irq_bit = irq;
`else
  assign irq_bit = 1'b0;
`endif

  // Indexed read mux over the register file.
  always_comb begin
    rd_data = 8'h00;
    case (addr)
      5'd0:    rd_data = {locked, 6'b000000, irq_bit};
      5'd1:    rd_data = {7'b0000000, line[8]};
      5'd2:    rd_data = line[7:0];
      5'd3:    rd_data = 8'(period >> 8);
      5'd4:    rd_data = period[7:0];
      5'd5:    rd_data = {7'b0000000, lpf[8]};
      5'd6:    rd_data = lpf[7:0];
      default: rd_data = 8'h00;
    endcase
  end

  // CPU port. Reads are registered into DO and see the state from before
  // this edge's updates. Data-register writes have no effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      DO   <= 8'h00;
      addr <= '0;
    end else if (cs) begin
      if (!AD && !rw) begin
        addr <= DI[4:0];
      end
      if (rw) begin
        DO <= AD ? rd_data : {3'b000, addr};
      end
    end
  end

endmodule

// File: tb/tb_sync_decoder.sv
// Testbench for sync_decoder. A reference model works at the level of whole
// sync pulses. It records the width of each low run on sync_in and turns it
// into an event three edges after the rise is sampled. Each event then
// updates line, period, frame and lock state with plain arithmetic. The CPU
// port is exercised with random accesses plus a few directed reads.

module tb_sync_decoder;

  localparam int CNT_W  = 10;
  localparam int EQ_MAX = 28;
  localparam int HS_MAX = 64;
  localparam int TOL    = 4;
  localparam int LOCK_N = 8;
  localparam int CMAX   = (1 << CNT_W) - 1;
`ifdef SYNC_DECODER_IRQ_EN
  localparam int IRQ = 1;
`else
  localparam int IRQ = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             sync_in;
  logic             AD;
  logic [7:0]       DI;
  logic [7:0]       DO;
  logic             rw;
  logic             cs;
  logic             hs_pulse;
  logic             vs_pulse;
  logic             locked;
  logic [8:0]       line;
  logic [CNT_W-1:0] hcnt;
`ifdef SYNC_DECODER_IRQ_EN
  logic             irq;
`endif

  sync_decoder #(
    .CNT_W (CNT_W),
    .EQ_MAX(EQ_MAX),
    .HS_MAX(HS_MAX),
    .TOL   (TOL),
    .LOCK_N(LOCK_N)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sync_in (sync_in),
    .AD      (AD),
    .DI      (DI),
    .DO      (DO),
    .rw      (rw),
    .cs      (cs),
    .hs_pulse(hs_pulse),
    .vs_pulse(vs_pulse),
    .locked  (locked),
    .line    (line),
    .hcnt    (hcnt)
`ifdef SYNC_DECODER_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int at;
    int width;
  } evt_t;

  evt_t pend[$];
  int   cyc = 0;
  int   low_run, since_hs;
  bit   prev_s;
  int   m_period, m_line, m_lpf, m_broad, m_good, m_addr, m_do;
  bit   m_skip, m_locked, m_irq, m_hs, m_vs;

  function automatic void model_reset();
    pend.delete();
    low_run  = 0;
    prev_s   = 1'b1;
    since_hs = 0;
    m_period = 0;
    m_line   = 0;
    m_lpf    = 0;
    m_broad  = 0;
    m_good   = 0;
    m_addr   = 0;
    m_do     = 0;
    m_skip   = 1'b1;
    m_locked = 1'b0;
    m_irq    = 1'b0;
    m_hs     = 1'b0;
    m_vs     = 1'b0;
  endfunction

  function automatic int reg_val(input int a);
    case (a)
      0:       return (m_locked ? 128 : 0) + (m_irq ? 1 : 0);
      1:       return m_line / 256;
      2:       return m_line % 256;
      3:       return m_period / 256;
      4:       return m_period % 256;
      5:       return m_lpf / 256;
      6:       return m_lpf % 256;
      default: return 0;
    endcase
  endfunction

  // Advance the model by one clock edge, using the inputs the DUT sampled.
  function automatic void model_edge();
    bit ev_hs, ev_eq, ev_br, sat, tol, clr;
    int w, np;
    ev_hs = 0; ev_eq = 0; ev_br = 0;
    // The CPU sees the state as it was before this edge.
    clr = 0;
    if (cs && rw) begin
      m_do = AD ? reg_val(m_addr) : m_addr;
      clr  = AD && (m_addr == 0);
    end
    if (cs && !rw && !AD) m_addr = int'(DI[4:0]);
    if (pend.size() > 0 && pend[0].at == cyc) begin
      w = pend.pop_front().width;
      if (w <= EQ_MAX)      ev_eq = 1;
      else if (w <= HS_MAX) ev_hs = 1;
      else                  ev_br = 1;
    end
    sat  = (since_hs >= CMAX);
    m_hs = 0;
    m_vs = 0;
    since_hs++;
    if (ev_hs) begin
      np = (since_hs > CMAX) ? CMAX : since_hs;
      if (m_skip) begin
        m_skip = 0;
      end else begin
        tol = ((np > m_period) ? np - m_period : m_period - np) <= TOL;
        if (m_locked) begin
          if (!tol) begin m_locked = 0; m_good = 0; end
        end else if (tol) begin
          m_good++;
          if (m_good == LOCK_N) m_locked = 1;
        end else begin
          m_good = 0;
        end
      end
      m_period = np;
      since_hs = 0;
      m_line   = (m_line < 511) ? m_line + 1 : 511;
      m_broad  = 0;
      m_hs     = 1;
    end
    if (ev_eq) begin
      m_skip  = 1;
      m_broad = 0;
    end
    if (ev_br) begin
      m_skip = 1;
      if (m_broad == 2) begin
        m_vs   = 1;
        m_lpf  = m_line;
        m_line = 0;
      end
      m_broad = (m_broad < 7) ? m_broad + 1 : 7;
    end
    if (sat) begin
      m_locked = 0;
      m_good   = 0;
    end
    if (IRQ != 0) begin
      if (clr)  m_irq = 0;
      if (m_vs) m_irq = 1;
    end
    // Record sync_in low runs; each rise becomes an event three edges later.
    if (sync_in && !prev_s) pend.push_back('{at: cyc + 3, width: (low_run > CMAX) ? CMAX : low_run});
    low_run = sync_in ? 0 : low_run + 1;
    prev_s  = sync_in;
    cyc++;
  endfunction

  task automatic compare_all();
    check("hs_pulse", hs_pulse, m_hs);
    check("vs_pulse", vs_pulse, m_vs);
    check("locked", locked, m_locked);
    check("line", line, m_line);
    check("hcnt", hcnt, (since_hs > CMAX) ? CMAX : since_hs);
    check("DO", DO, m_do);
`ifdef SYNC_DECODER_IRQ_EN
    check("irq", irq, m_irq);
`endif
  endtask

  // ---------------- stimulus ----------------
  bit cpu_hold = 0;
  int hs_n = 0, vs_n = 0, lock_at = 0;
  bit lock_seen = 0;

  // One clock: drive at the falling edge, let the DUT take the rising edge,
  // then compare 1 time unit later.
  task automatic tick(input bit s);
    sync_in = s;
    if (!cpu_hold) begin
      cs = ($urandom_range(0, 7) == 0);
      rw = 1'($urandom);
      AD = 1'($urandom);
      DI = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
    end
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (hs_pulse === 1'b1) hs_n++;
    if (vs_pulse === 1'b1) vs_n++;
    if (locked === 1'b1 && !lock_seen) begin
      lock_seen = 1;
      lock_at   = hs_n;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1);
  endtask

  task automatic sync_line(input int low, input int per);
    repeat (low) tick(1'b0);
    repeat (per - low) tick(1'b1);
  endtask

  task automatic cpu_op(input bit ad, input bit r, input logic [7:0] d);
    cpu_hold = 1;
    cs = 1'b1; AD = ad; rw = r; DI = d;
    tick(1'b1);
    cs = 1'b0;
  endtask

  // Asynchronous reset applied between clock edges; outputs must clear at once.
  task automatic do_reset();
    rst = 1'b1;
    sync_in = 1'b1;
    cs = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int r, low, per;
    rst = 1'b1; sync_in = 1'b1; cs = 1'b0; rw = 1'b1; AD = 1'b0; DI = '0;
    @(negedge clk);
    do_reset();

    // Steady 512-clk lines: the first strobe is skipped and the next
    // eight are in tolerance, so lock arrives on the 9th strobe.
    idle(470);
    repeat (20) sync_line(38, 512);
    check("lock_at_hs", lock_at, 9);

    // One long line breaks lock; steady lines bring it back.
    sync_line(38, 520);
    repeat (10) sync_line(38, 512);

    // Vertical interval with no CPU traffic, so the frame interrupt survives.
    cpu_hold = 1; cs = 1'b0;
    vs_n = 0;
    repeat (5) sync_line(19, 256);
    repeat (5) sync_line(218, 256);
    repeat (5) sync_line(19, 256);
    repeat (6) sync_line(38, 512);
    check("vs_count", vs_n, 1);

    // Directed register reads (period is 512 here).
    cpu_op(1'b0, 1'b0, 8'h04);
    cpu_op(1'b1, 1'b1, 8'h00);
    check("rd_period_lo", DO, 8'h00);
    cpu_op(1'b0, 1'b0, 8'h03);
    cpu_op(1'b1, 1'b1, 8'h00);
    check("rd_period_hi", DO, 8'h02);
    cpu_op(1'b0, 1'b1, 8'h00);
    check("rd_addr", DO, 8'h03);
    cpu_op(1'b0, 1'b0, 8'h00);
    cpu_op(1'b1, 1'b1, 8'h00);
    check("status_irq", DO[0], IRQ);
`ifdef SYNC_DECODER_IRQ_EN
    check("irq_cleared", irq, 1'b0);
`endif
    cpu_op(1'b1, 1'b0, 8'hFF);
    cpu_op(1'b0, 1'b1, 8'h00);
    check("ad1_write_ignored", DO, 8'h00);
    cpu_hold = 0;

    // Random mix of pulse classes, widths and periods.
    for (int i = 0; i < 25; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        low = int'($urandom_range(1, EQ_MAX));
        per = 256;
      end else if (r == 1) begin
        low = int'($urandom_range(HS_MAX + 1, 300));
        per = low + int'($urandom_range(20, 100));
      end else if (r == 2) begin
        low = int'($urandom_range(EQ_MAX + 1, HS_MAX));
        per = 300 + int'($urandom_range(0, 400));
      end else begin
        low = int'($urandom_range(EQ_MAX + 1, HS_MAX));
        per = 506 + int'($urandom_range(0, 12));
      end
      sync_line(low, per);
    end

    // No sync at all: the counter saturates and lock is lost.
    idle(1100);
    check("hcnt_saturated", hcnt, CMAX);
    check("unlocked_on_sat", locked, 1'b0);

    // Sync stuck low: the width saturates and the pulse counts as broad.
    repeat (1100) tick(1'b0);
    idle(600);

    // Many short lines with no frame start: line saturates at 511.
    repeat (515) sync_line(35, 60);
    check("line_saturated", line, 511);

    // Reset in the middle of a sync pulse, then lock again.
    repeat (4) sync_line(38, 512);
    repeat (20) tick(1'b0);
    do_reset();
    idle(470);
    repeat (12) sync_line(38, 512);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
